trap_ctrl: RTL
==============

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of PC, cause and CSR data paths.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have port valid_i  in  1  executing instruction is valid this cycle.
REQ-004 SHALL have port pc_i  in  DATA_WIDTH  PC of the executing instruction.
REQ-005 SHALL have ports ecall_i, ebreak_i, illegal_i, mret_i  in  1 each  decoded flags, qualified by valid_i.
REQ-006 SHALL have port irq_ext_i  in  1  level-sensitive machine external interrupt request.
REQ-007 SHALL have port mie_i  in  1  mstatus.MIE from the CSR file.
REQ-008 SHALL have ports csr_mtvec_i, csr_mepc_i  in  DATA_WIDTH  current mtvec and mepc from the CSR file.
REQ-009 SHALL have ports intr_o  out  1,  intr_no_o  out  DATA_WIDTH,  intr_epc_o  out  DATA_WIDTH: trap commit to the CSR file.
REQ-010 SHALL have port mret_o  out  1  mret commit pulse to the CSR file.
REQ-011 SHALL have ports redirect_valid_o  out  1,  redirect_pc_o  out  DATA_WIDTH,  redirect_ready_i  in  1: fetch redirect handshake.
REQ-012 SHALL have port stall_o  out  1  freezes PC update and register/CSR writeback of the current instruction.
REQ-013 SHALL have port trap_cnt_o  out  DATA_WIDTH  count of traps taken.

Function
REQ-014 SHALL implement FSM states IDLE, COMMIT, REDIRECT, with transitions IDLE->COMMIT on an event, COMMIT->REDIRECT unconditionally, and REDIRECT->IDLE on redirect_valid_o & redirect_ready_i.
REQ-015 SHALL define an event in IDLE as valid_i & (irq_take | illegal_i | ebreak_i | ecall_i | mret_i), where irq_take = irq_ext_i & mie_i.
REQ-016 SHALL resolve simultaneous events by fixed priority: irq_take > illegal_i > ebreak_i > ecall_i > mret_i.
REQ-017 SHALL latch the following causes: irq = {1'b1, (DATA_WIDTH-1)'d11}; illegal = 2; ebreak = 3; ecall = 11.
REQ-018 SHALL latch intr_epc_o = pc_i for every trap, including irq, where the interrupted instruction is not executed.
REQ-019 SHALL assert stall_o combinationally in the event cycle, and in every non-IDLE state.
REQ-020 SHALL hold intr_o high for exactly the single COMMIT cycle for traps, with intr_no_o/intr_epc_o stable in that cycle.
REQ-021 SHALL hold mret_o high for exactly the single COMMIT cycle for mret, and SHALL keep intr_o low in that case.
REQ-022 SHALL assert redirect_valid_o throughout REDIRECT, with redirect_pc_o = csr_mtvec_i with bits [1:0] cleared for a trap, or csr_mepc_i with bits [1:0] cleared for mret; the value is sampled on COMMIT->REDIRECT and held stable until handshake.
REQ-023 SHALL ignore valid_i and all event inputs outside IDLE.
REQ-024 SHALL increment trap_cnt_o by 1 in each COMMIT cycle with intr_o=1, saturating at all-ones and never incrementing for mret.
REQ-025 SHALL keep intr_o, mret_o and redirect_valid_o mutually exclusive in any cycle.
REQ-026 SHALL give the latency from the event cycle T as: intr_o/mret_o at T+1, redirect_valid_o from T+2; the earliest possible return to IDLE is T+3.

Reset
REQ-027 SHALL, on rst, go to IDLE and drive intr_o=0, mret_o=0, redirect_valid_o=0, stall_o=0, intr_no_o=0, intr_epc_o=0, redirect_pc_o=0 and trap_cnt_o=0.
REQ-028 SHALL, on rst asserted in COMMIT or REDIRECT, abort the operation: no intr_o/mret_o pulse, and no redirect after reset.

Configuration
REQ-029 SHALL, with TRAP_CTRL_IRQ_EN defined, implement irq_take per REQ-015.
REQ-030 SHALL, without TRAP_CTRL_IRQ_EN, tie irq_take to 0, leave irq_ext_i and mie_i unused, and take only synchronous traps and mret.

Structure
REQ-031 SHALL place the FSM state enum and the cause constants (CAUSE_ILLEGAL, CAUSE_EBREAK, CAUSE_ECALL_M, CAUSE_IRQ_EXT_M) in shared package trap_pkg.
REQ-032 SHALL use one combinational sub-module, trap_cause_enc, for priority resolution and cause encoding; all state SHALL reside in trap_ctrl.

Verification
REQ-033 SHALL cover: ecall at pc_i=0x80000010, mtvec=0x80000104 -> intr_o at T+1 with intr_no_o=11 and intr_epc_o=0x80000010; redirect_pc_o=0x80000104; trap_cnt_o=1.
REQ-034 SHALL cover: mret with mepc=0x80000013 -> mret_o at T+1, intr_o=0, redirect_pc_o=0x80000010, trap_cnt_o unchanged.
REQ-035 SHALL cover: illegal_i+ecall_i+irq_ext_i together with mie_i=1 -> cause 0x8000000B; with mie_i=0 -> cause 2; with the macro undefined -> cause 2 in both cases.
REQ-036 SHALL cover: redirect_ready_i held low for 5 cycles -> redirect_valid_o and redirect_pc_o stable, stall_o=1, and a new ecall during the wait is ignored.
REQ-037 SHALL cover: rst asserted in COMMIT -> next cycle IDLE, all outputs 0, no intr_o pulse.
REQ-038 SHALL cover: trap_cnt_o preloaded to all-ones via force, then an ecall -> trap_cnt_o remains all-ones.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared FSM state type and trap cause codes for trap_ctrl.
package trap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCommit,
    StRedirect
  } trap_state_e;

  // Exception codes; the interrupt flag (MSB) is applied by the encoder.
  localparam int unsigned CAUSE_ILLEGAL   = 2;
  localparam int unsigned CAUSE_EBREAK    = 3;
  localparam int unsigned CAUSE_ECALL_M   = 11;
  localparam int unsigned CAUSE_IRQ_EXT_M = 11;

endpackage

// File: rtl/trap_cause_enc.sv
// Fixed-priority trap resolution and mcause encoding (purely combinational).
module trap_cause_enc #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  irq_take_i,
  input  logic                  illegal_i,
  input  logic                  ebreak_i,
  input  logic                  ecall_i,
  input  logic                  mret_i,
  output logic                  event_o,
  output logic                  trap_o,
  output logic [DATA_WIDTH-1:0] cause_o
);
  import trap_pkg::*;

  always_comb begin
    trap_o  = irq_take_i | illegal_i | ebreak_i | ecall_i;
    event_o = trap_o | mret_i;
    cause_o = '0;
    if (irq_take_i) begin
      cause_o                 = DATA_WIDTH'(CAUSE_IRQ_EXT_M);
      cause_o[DATA_WIDTH-1]   = 1'b1;
    end else if (illegal_i) begin
      cause_o = DATA_WIDTH'(CAUSE_ILLEGAL);
    end else if (ebreak_i) begin
      cause_o = DATA_WIDTH'(CAUSE_EBREAK);
    end else if (ecall_i) begin
      cause_o = DATA_WIDTH'(CAUSE_ECALL_M);
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret controller: commit to CSRs, then redirect fetch.
// Define TRAP_CTRL_IRQ_EN to enable the machine external interrupt path.
module trap_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  ecall_i,
  input  logic                  ebreak_i,
  input  logic                  illegal_i,
  input  logic                  mret_i,
  input  logic                  irq_ext_i,
  input  logic                  mie_i,
  input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
  input  logic [DATA_WIDTH-1:0] csr_mepc_i,
  output logic                  intr_o,
  output logic [DATA_WIDTH-1:0] intr_no_o,
  output logic [DATA_WIDTH-1:0] intr_epc_o,
  output logic                  mret_o,
  output logic                  redirect_valid_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  input  logic                  redirect_ready_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] trap_cnt_o
);
  import trap_pkg::*;

  trap_state_e           state_q, state_d;
  logic                  intr_q, intr_d;
  logic                  mret_q, mret_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] cause_q, cause_d;
  logic [DATA_WIDTH-1:0] epc_q, epc_d;
  logic [DATA_WIDTH-1:0] rpc_q, rpc_d;
  logic [DATA_WIDTH-1:0] trap_cnt_q, trap_cnt_d;

  logic                  irq_take;
  logic                  enc_event;
  logic                  enc_trap;
  logic [DATA_WIDTH-1:0] enc_cause;
  logic                  take_event;

`ifdef TRAP_CTRL_IRQ_EN
  assign irq_take = irq_ext_i & mie_i;
`else
  logic unused_irq;
  assign irq_take   = 1'b0;
  assign unused_irq = irq_ext_i ^ mie_i;
`endif

  trap_cause_enc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_trap_cause_enc (
    .irq_take_i(valid_i & irq_take),
    .illegal_i (valid_i & illegal_i),
    .ebreak_i  (valid_i & ebreak_i),
    .ecall_i   (valid_i & ecall_i),
    .mret_i    (valid_i & mret_i),
    .event_o   (enc_event),
    .trap_o    (enc_trap),
    .cause_o   (enc_cause)
  );

  // Inputs only matter in IDLE; everywhere else they are ignored.
  assign take_event = (state_q == StIdle) & enc_event;

  always_comb begin
    state_d    = state_q;
    intr_d     = 1'b0;
    mret_d     = 1'b0;
    rvalid_d   = rvalid_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    rpc_d      = rpc_q;
    trap_cnt_d = trap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (take_event) begin
          state_d = StCommit;
          intr_d  = enc_trap;
          mret_d  = ~enc_trap;
          if (enc_trap) begin
            cause_d = enc_cause;
            epc_d   = pc_i;
          end
        end
      end
      StCommit: begin
        state_d  = StRedirect;
        rvalid_d = 1'b1;
        // Target is sampled here and held until the fetch handshake.
        rpc_d    = intr_q ? {csr_mtvec_i[DATA_WIDTH-1:2], 2'b00}
                          : {csr_mepc_i[DATA_WIDTH-1:2], 2'b00};
        if (intr_q && (trap_cnt_q != '1)) begin
          trap_cnt_d = trap_cnt_q + DATA_WIDTH'(1);
        end
      end
      StRedirect: begin
        if (rvalid_q && redirect_ready_i) begin
          state_d  = StIdle;
          rvalid_d = 1'b0;
        end
      end
      default: begin
        state_d  = StIdle;
        rvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      intr_q     <= 1'b0;
      mret_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      cause_q    <= '0;
      epc_q      <= '0;
      rpc_q      <= '0;
      trap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      intr_q     <= intr_d;
      mret_q     <= mret_d;
      rvalid_q   <= rvalid_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      rpc_q      <= rpc_d;
      trap_cnt_q <= trap_cnt_d;
    end
  end

  // Reset in COMMIT/REDIRECT suppresses the pulse in that very cycle.
  assign intr_o           = intr_q & ~rst;
  assign mret_o           = mret_q & ~rst;
  assign redirect_valid_o = rvalid_q & ~rst;
  assign stall_o          = ~rst & (take_event | (state_q != StIdle));
  assign intr_no_o        = cause_q;
  assign intr_epc_o       = epc_q;
  assign redirect_pc_o    = rpc_q;
  assign trap_cnt_o       = trap_cnt_q;

endmodule
